// File: rtl/down_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_pkg
// Purpose  : Shared state encoding and default width for the down counter.
// Revision : 1.0 - initial release
// ============================================================================
package down_counter_pkg;

    localparam int c_WIDTH_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage : down_counter_pkg
`default_nettype wire

// File: rtl/down_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_if
// Purpose  : Control and status bundle of the down counter.
// Revision : 1.0 - initial release
// ============================================================================
interface down_counter_if #(
    parameter int WIDTH = down_counter_pkg::c_WIDTH_DEFAULT
);
    logic             i_load;
    logic [WIDTH-1:0] i_load_value;
    logic             i_start;
    logic             i_pause;
    logic             i_auto_reload;
    logic [WIDTH-1:0] o_value;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_reload_cnt;

    modport master (
        output i_load, i_load_value, i_start, i_pause, i_auto_reload,
        input  o_value, o_busy, o_done, o_reload_cnt
    );

    modport slave (
        input  i_load, i_load_value, i_start, i_pause, i_auto_reload,
        output o_value, o_busy, o_done, o_reload_cnt
    );
endinterface : down_counter_if
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module   : down_counter
// Purpose  : Loadable down counter with start, pause and auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  wire logic   i_clock,
    input  wire logic   i_reset_sync,
    down_counter_if.slave bus
);

    state_t           r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_value,  w_value_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic [WIDTH-1:0] r_rcnt,   w_rcnt_nxt;
    logic             r_done,   w_done_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_value_nxt  = r_value;
        w_reload_nxt = r_reload;
        w_rcnt_nxt   = r_rcnt;
        w_done_nxt   = 1'b0;

        if (bus.i_load) begin
            w_reload_nxt = bus.i_load_value;
            w_value_nxt  = bus.i_load_value;
            w_rcnt_nxt   = '0;
            if (r_state != IDLE) begin
                w_state_nxt = (bus.i_load_value != '0) ? RUN : IDLE;
            end
        end else if (bus.i_pause) begin
            if (r_state == RUN) begin
                w_state_nxt = PAUSE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        if (r_value != '0) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                // Leaving PAUSE decrements in the same cycle, so it shares RUN's path.
                RUN, PAUSE: begin
                    w_state_nxt = RUN;
                    if (r_value == WIDTH'(1)) begin
                        w_done_nxt = 1'b1;
                        if (bus.i_auto_reload) begin
                            w_value_nxt = r_reload;
                            w_rcnt_nxt  = r_rcnt + WIDTH'(1);
                        end else begin
                            w_value_nxt = '0;
                            w_state_nxt = IDLE;
                        end
                    end else if (r_value == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_value_nxt = r_value - WIDTH'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset_sync) begin
            r_state  <= IDLE;
            r_value  <= '0;
            r_reload <= '0;
            r_rcnt   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_value  <= w_value_nxt;
            r_reload <= w_reload_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.o_value      = r_value;
    assign bus.o_busy       = (r_state != IDLE);
    assign bus.o_done       = r_done;
    assign bus.o_reload_cnt = r_rcnt;

endmodule : down_counter
`default_nettype wire
